// File: rtl/pll_mode_ctrl.sv
// Mode sequencer for a Gowin PLLVR in dynamic-divider mode: table-driven divider selects,
// PLL reset pulsing, lock qualification with retry, and pixel-domain reset release.
// Optional build macro PLL_LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter.
`timescale 1ns/1ps

module pll_mode_ctrl #(
    parameter int          NUM_MODES    = 4,
    parameter int          MODE_W       = 2,
    parameter logic [23:0] IDIV_TABLE   = 24'h000000,
    parameter logic [23:0] FBDIV_TABLE  = 24'h000009,
    parameter logic [23:0] ODIV_TABLE   = 24'h000004,
    parameter int          RESET_CYCLES = 16,
    parameter int          LOCK_STABLE  = 1024,
    parameter int          LOCK_TIMEOUT = 65535,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic              clkin,
    input  logic              resetn,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              mode_req,
    output logic              mode_ready,
    output logic              mode_done,
    output logic              mode_bad,
    output logic [MODE_W-1:0] cur_mode,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        idsel,
    output logic [5:0]        fbdsel,
    output logic [5:0]        odsel,
    output logic              pix_resetn,
    output logic              locked,
    output logic              error,
    output logic [7:0]        lock_loss_cnt
);

    localparam int CNT_MAX = (RESET_CYCLES > LOCK_STABLE)
                           ? ((RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT)
                           : ((LOCK_STABLE  > LOCK_TIMEOUT) ? LOCK_STABLE  : LOCK_TIMEOUT);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {
        S_APPLY,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    function automatic logic [5:0] tbl_entry(input logic [23:0] tbl, input logic [MODE_W-1:0] idx);
        return tbl[6*int'(idx) +: 6];
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic [CNT_W-1:0]  r_cnt;
    logic [RTY_W-1:0]  r_tries;
    logic [MODE_W-1:0] r_cur_mode;
    logic [5:0]        r_idsel;
    logic [5:0]        r_fbdsel;
    logic [5:0]        r_odsel;
    logic              r_pll_reset;
    logic              r_pix_resetn;
    logic              r_done;
    logic              r_bad;

    logic w_lock_s;
    logic w_ready;
    logic w_mode_ok;
    logic w_accept;
    logic w_bad;
    logic w_loss;
    logic w_timeout;
    logic w_out_of_tries;

    // LOCK comes straight from the PLL analog block; only the second flop is used by the FSM.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here make each flop sample the previous stage's old value.
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s       = r_sync2;
    assign w_ready        = (r_state == S_RUN) || (r_state == S_FAIL);
    assign w_mode_ok      = (int'(mode_sel) < NUM_MODES);
    assign w_accept       = mode_req && w_ready && w_mode_ok;
    assign w_bad          = mode_req && w_ready && !w_mode_ok;
    assign w_loss         = (r_state == S_RUN) && !w_lock_s;
    assign w_timeout      = (r_state == S_WAIT_LOCK) && !w_lock_s && (r_cnt == TMO_LAST);
    assign w_out_of_tries = (int'(r_tries) + 1 >= MAX_RETRIES);

    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_APPLY: begin
                if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_lock_s)       w_state_nxt = S_STABLE;
                else if (w_timeout) w_state_nxt = w_out_of_tries ? S_FAIL : S_APPLY;
            end
            S_STABLE: begin
                if (!w_lock_s)              w_state_nxt = S_WAIT_LOCK;
                else if (r_cnt == STB_LAST) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!w_lock_s) w_state_nxt = S_APPLY;
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_APPLY;
            end
        endcase
        // A request always wins, even over a lock loss in the same cycle.
        if (w_accept) w_state_nxt = S_APPLY;
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_APPLY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_cnt != CNT_SAT)  r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_tries <= '0;
        end else if (w_accept || w_loss) begin
            r_tries <= '0;
        end else if (w_timeout && (int'(r_tries) < MAX_RETRIES)) begin
            r_tries <= r_tries + RTY_W'(1);
        end
    end

    // Divider selects move only on acceptance, which always lands in APPLY with pll_reset high.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_cur_mode <= '0;
            r_idsel    <= IDIV_TABLE[5:0];
            r_fbdsel   <= FBDIV_TABLE[5:0];
            r_odsel    <= ODIV_TABLE[5:0];
        end else if (w_accept) begin
            r_cur_mode <= mode_sel;
            r_idsel    <= tbl_entry(IDIV_TABLE, mode_sel);
            r_fbdsel   <= tbl_entry(FBDIV_TABLE, mode_sel);
            r_odsel    <= tbl_entry(ODIV_TABLE, mode_sel);
        end
    end

    // Reset outputs are registered so the PLL and pixel domain never see decode glitches.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_pll_reset  <= 1'b1;
            r_pix_resetn <= 1'b0;
            r_done       <= 1'b0;
            r_bad        <= 1'b0;
        end else begin
            r_pll_reset  <= (w_state_nxt == S_APPLY);
            r_pix_resetn <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_RUN) && (r_state != S_RUN);
            r_bad        <= w_bad;
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign mode_ready = w_ready;
    assign mode_done  = r_done;
    assign mode_bad   = r_bad;
    assign cur_mode   = r_cur_mode;
    assign pll_reset  = r_pll_reset;
    assign idsel      = r_idsel;
    assign fbdsel     = r_fbdsel;
    assign odsel      = r_odsel;
    assign pix_resetn = r_pix_resetn;
    assign locked     = (r_state == S_RUN);
    assign error      = (r_state == S_FAIL);

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Self-checking bench for pll_mode_ctrl: a timestamp-based phase model checked every cycle,
// plus directed scenarios with hand-computed latencies.
`timescale 1ns/1ps

module tb_pll_mode_ctrl;

    localparam int N_MODES = 3;
    localparam int RST_CYC = 16;
    localparam int STB_CYC = 1024;
    localparam int TMO_CYC = 200;
    localparam int RETRIES = 3;

`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit LLC_EN = 1'b1;
`else
    localparam bit LLC_EN = 1'b0;
`endif

    logic       clkin = 1'b0;
    logic       resetn = 1'b1;
    logic [1:0] mode_sel = 2'd0;
    logic       mode_req = 1'b0;
    logic       pll_lock = 1'b0;
    logic       mode_ready, mode_done, mode_bad, pll_reset, pix_resetn, locked, error;
    logic [1:0] cur_mode;
    logic [5:0] idsel, fbdsel, odsel;
    logic [7:0] lock_loss_cnt;

    pll_mode_ctrl #(
        .NUM_MODES   (N_MODES),
        .MODE_W      (2),
        .IDIV_TABLE  ({6'd3,  6'd2,  6'd1,  6'd0}),
        .FBDIV_TABLE ({6'd39, 6'd29, 6'd19, 6'd9}),
        .ODIV_TABLE  ({6'd16, 6'd2,  6'd8,  6'd4}),
        .RESET_CYCLES(RST_CYC),
        .LOCK_STABLE (STB_CYC),
        .LOCK_TIMEOUT(TMO_CYC),
        .MAX_RETRIES (RETRIES)
    ) dut (
        .clkin        (clkin),
        .resetn       (resetn),
        .mode_sel     (mode_sel),
        .mode_req     (mode_req),
        .mode_ready   (mode_ready),
        .mode_done    (mode_done),
        .mode_bad     (mode_bad),
        .cur_mode     (cur_mode),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .idsel        (idsel),
        .fbdsel       (fbdsel),
        .odsel        (odsel),
        .pix_resetn   (pix_resetn),
        .locked       (locked),
        .error        (error),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clkin = ~clkin;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {PH_APPLY, PH_WAIT, PH_STABLE, PH_RUN, PH_FAIL} phase_t;

    int     id_tab[4] = '{0, 1, 2, 3};
    int     fb_tab[4] = '{9, 19, 29, 39};
    int     od_tab[4] = '{4, 8, 2, 16};
    phase_t m_phase = PH_APPLY;
    int     cyc = 0;
    int     m_enter = 0;
    int     m_mode = 0;
    int     m_tries = 0;
    int     m_loss = 0;
    bit     m_done = 0;
    bit     m_bad = 0;
    bit     lock_pipe[$];

    function automatic void go(input phase_t p);
        m_phase = p;
        m_enter = cyc;
    endfunction

    function automatic void model_reset();
        m_phase = PH_APPLY;
        m_enter = cyc;
        m_mode  = 0;
        m_tries = 0;
        m_loss  = 0;
        m_done  = 0;
        m_bad   = 0;
        lock_pipe.delete();
        lock_pipe.push_back(1'b0);
        lock_pipe.push_back(1'b0);
    endfunction

    always @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            model_reset();
        end else begin
            bit ls;
            bit acc;
            int k;
            cyc++;
            ls = lock_pipe.pop_front();
            lock_pipe.push_back(pll_lock);
            k = cyc - m_enter;
            acc = 0;
            m_done = 0;
            m_bad = 0;
            if (mode_req && (m_phase == PH_RUN || m_phase == PH_FAIL)) begin
                if (int'(mode_sel) < N_MODES) acc = 1;
                else m_bad = 1;
            end
            case (m_phase)
                PH_APPLY:  if (k == RST_CYC) go(PH_WAIT);
                PH_WAIT: begin
                    if (ls) go(PH_STABLE);
                    else if (k == TMO_CYC) begin
                        m_tries++;
                        go(m_tries < RETRIES ? PH_APPLY : PH_FAIL);
                    end
                end
                PH_STABLE: begin
                    if (!ls) go(PH_WAIT);
                    else if (k == STB_CYC) begin
                        go(PH_RUN);
                        m_done = 1;
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        m_tries = 0;
                        go(PH_APPLY);
                    end
                end
                default: ;
            endcase
            if (acc) begin
                m_mode  = int'(mode_sel);
                m_tries = 0;
                go(PH_APPLY);
            end
        end
    end

    always @(negedge clkin) begin
        if (chk_en) begin
            check("cyc_pll_reset",  pll_reset,     int'(m_phase == PH_APPLY));
            check("cyc_pix_resetn", pix_resetn,    int'(m_phase == PH_RUN));
            check("cyc_locked",     locked,        int'(m_phase == PH_RUN));
            check("cyc_error",      error,         int'(m_phase == PH_FAIL));
            check("cyc_mode_ready", mode_ready,    int'(m_phase == PH_RUN || m_phase == PH_FAIL));
            check("cyc_mode_done",  mode_done,     int'(m_done));
            check("cyc_mode_bad",   mode_bad,      int'(m_bad));
            check("cyc_cur_mode",   cur_mode,      m_mode);
            check("cyc_idsel",      idsel,         id_tab[m_mode]);
            check("cyc_fbdsel",     fbdsel,        fb_tab[m_mode]);
            check("cyc_odsel",      odsel,         od_tab[m_mode]);
            check("cyc_loss_cnt",   lock_loss_cnt, LLC_EN ? m_loss : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic req(input logic [1:0] sel);
        mode_sel = sel;
        mode_req = 1'b1;
        @(negedge clkin);
        mode_req = 1'b0;
    endtask

    task automatic count_to_locked(input string name, input int exp);
        int n = 0;
        while (!locked && n < 3000) begin
            @(negedge clkin);
            n++;
        end
        check(name, n, exp);
        check({name, "_done"}, mode_done, 1);
    endtask

    task automatic relock();
        int n = 0;
        while (pll_reset && n < 1000) begin
            @(negedge clkin);
            n++;
        end
        check("relock_prst_low", pll_reset, 0);
        repeat (20) @(negedge clkin);
        pll_lock = 1'b1;
        count_to_locked("relock_latency", 2 + 1 + STB_CYC);
    endtask

    initial begin
        int n;
        int n_rise;
        bit prev;

        #3 resetn = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_pll_reset", pll_reset, 1);
        check("rst_fbdsel", fbdsel, 9);
        check("rst_odsel", odsel, 4);
        check("rst_mode_ready", mode_ready, 0);
        repeat (3) @(negedge clkin);

        // Boot: pll_reset width, then lock 100 cycles after it falls.
        resetn = 1'b1;
        n = 0;
        while (pll_reset && n < 100) begin
            n++;
            @(negedge clkin);
        end
        check("boot_reset_width", n, RST_CYC);
        repeat (100) @(negedge clkin);
        pll_lock = 1'b1;
        count_to_locked("boot_lock_latency", 2 + 1 + STB_CYC);
        check("boot_fbdsel", fbdsel, 9);
        check("boot_odsel", odsel, 4);
        @(negedge clkin);
        check("boot_done_pulse", mode_done, 0);

        // Invalid index: pulse only, nothing else moves.
        req(2'd3);
        check("bad_pulse", mode_bad, 1);
        check("bad_cur_mode", cur_mode, 0);
        check("bad_locked", locked, 1);
        @(negedge clkin);
        check("bad_pulse_end", mode_bad, 0);

        // Mode switch to 1, with a one-cycle lock glitch in STABLE.
        pll_lock = 1'b0;
        req(2'd1);
        check("sw_pll_reset", pll_reset, 1);
        check("sw_pix_resetn", pix_resetn, 0);
        check("sw_cur_mode", cur_mode, 1);
        check("sw_idsel", idsel, 1);
        check("sw_fbdsel", fbdsel, 19);
        check("sw_odsel", odsel, 8);
        n = 0;
        while (pll_reset && n < 100) begin
            @(negedge clkin);
            n++;
        end
        repeat (20) @(negedge clkin);
        pll_lock = 1'b1;
        repeat (50) @(negedge clkin);
        pll_lock = 1'b0;
        @(negedge clkin);
        pll_lock = 1'b1;
        count_to_locked("glitch_restart", 2 + 1 + STB_CYC);

        // Lock loss in RUN: same mode re-applied.
        pll_lock = 1'b0;
        n = 0;
        while (pix_resetn && n < 10) begin
            @(negedge clkin);
            n++;
        end
        check("loss_pix_latency", n, 3);
        check("loss_cur_mode", cur_mode, 1);
        check("loss_pll_reset", pll_reset, 1);
        check("loss_cnt", lock_loss_cnt, LLC_EN ? 1 : 0);
        relock();

        // Request and lock loss on the same edge: request wins, loss still counted.
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        req(2'd0);
        check("race_cur_mode", cur_mode, 0);
        check("race_fbdsel", fbdsel, 9);
        check("race_pll_reset", pll_reset, 1);
        check("race_loss_cnt", lock_loss_cnt, LLC_EN ? 2 : 0);
        relock();

        // Timeout/retry to FAIL; an early request during APPLY is ignored.
        pll_lock = 1'b0;
        mode_sel = 2'd2;
        mode_req = 1'b1;
        n = 0;
        n_rise = 0;
        prev = 1'b0;
        while (!error && n < 2000) begin
            @(negedge clkin);
            n++;
            mode_req = (n == 3);
            mode_sel = (n == 3) ? 2'd1 : 2'd2;
            if (pll_reset && !prev) n_rise++;
            prev = pll_reset;
        end
        mode_req = 1'b0;
        check("tmo_latency", n, 1 + RETRIES * (RST_CYC + TMO_CYC));
        check("tmo_apply_pulses", n_rise, RETRIES);
        check("tmo_error", error, 1);
        check("tmo_ready", mode_ready, 1);
        check("tmo_cur_mode", cur_mode, 2);
        check("tmo_fbdsel", fbdsel, 29);
        req(2'd1);
        check("fail_exit_error", error, 0);
        check("fail_exit_prst", pll_reset, 1);
        check("fail_exit_mode", cur_mode, 1);
        check("fail_exit_ready", mode_ready, 0);
        relock();

        // Asynchronous reset in the middle of APPLY.
        req(2'd2);
        repeat (4) @(negedge clkin);
        #2 resetn = 1'b0;
        #1;
        check("arst_pll_reset", pll_reset, 1);
        check("arst_cur_mode", cur_mode, 0);
        check("arst_idsel", idsel, 0);
        check("arst_fbdsel", fbdsel, 9);
        check("arst_odsel", odsel, 4);
        check("arst_pix_resetn", pix_resetn, 0);
        check("arst_locked", locked, 0);
        check("arst_error", error, 0);
        check("arst_ready", mode_ready, 0);
        check("arst_loss_cnt", lock_loss_cnt, 0);
        repeat (3) @(negedge clkin);
        resetn = 1'b1;
        repeat (40) @(negedge clkin);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
